// File: rtl/ff_bank_pkg.sv
// Shared types and the per-bit next-state rule for the multi-mode flip-flop bank.
package ff_bank_pkg;

   typedef enum logic [1:0] {
      MODE_SR = 2'b00,
      MODE_JK = 2'b01,
      MODE_D  = 2'b10,
      MODE_T  = 2'b11
   } mode_e;

   // SR-mode response to the forbidden S=R=1 input
   localparam int POL_HOLD = 0;
   localparam int POL_SET  = 1;
   localparam int POL_RST  = 2;
   localparam int POL_TGL  = 3;

   function automatic logic next_bit(input mode_e mode, input int policy,
                                     input logic a, input logic b, input logic q);
      logic nxt;
      // NOTE: nxt gets a default before the case so every path assigns it; no latch-like hold is implied.
      nxt = q;
      case (mode)
         MODE_SR: begin
            case ({a, b})
               2'b10: nxt = 1'b1;
               2'b01: nxt = 1'b0;
               2'b11: begin
                  case (policy)
                     POL_SET: nxt = 1'b1;
                     POL_RST: nxt = 1'b0;
                     POL_TGL: nxt = ~q;
                     default: nxt = q;
                  endcase
               end
               default: nxt = q;
            endcase
         end
         MODE_JK: begin
            case ({a, b})
               2'b10:   nxt = 1'b1;
               2'b01:   nxt = 1'b0;
               2'b11:   nxt = ~q;
               default: nxt = q;
            endcase
         end
         MODE_D:  nxt = a;
         MODE_T:  nxt = q ^ a;
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multi_mode_ff_bank_if.sv
// Control/data bundle of the flip-flop bank; the bank is the slave side.
interface multi_mode_ff_bank_if
   import ff_bank_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             en;
   mode_e            mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             illegal_clr;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_bar;
   logic [WIDTH-1:0] illegal_flags;
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output en, mode, a, b, illegal_clr,
      input  q, q_bar, illegal_flags, illegal_cnt
   );

   modport slave (
      input  en, mode, a, b, illegal_clr,
      output q, q_bar, illegal_flags, illegal_cnt
   );
endinterface

// File: rtl/multi_mode_ff_bank_ff_cell.sv
// One storage bit of the bank plus its sticky SR-illegal flag.
module ff_cell
   import ff_bank_pkg::*;
#(
   parameter logic RESET_BIT      = 1'b0,
   parameter int   SR_BOTH_POLICY = POL_HOLD
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en,
   input  mode_e mode,
   input  logic  a,
   input  logic  b,
   input  logic  illegal_clr,
   output logic  q,
   output logic  illegal_flag,
   output logic  illegal_hit
);

   assign illegal_hit = en && (mode == MODE_SR) && a && b;

   // NOTE: sequential state uses non-blocking assignments so all cells update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q            <= RESET_BIT;
         illegal_flag <= 1'b0;
      end else begin
         if (en)
            q <= next_bit(mode, SR_BOTH_POLICY, a, b, q);
         // a new illegal event beats a simultaneous clear
         if (illegal_hit)
            illegal_flag <= 1'b1;
         else if (illegal_clr)
            illegal_flag <= 1'b0;
      end
   end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH runtime-selectable SR/JK/D/T flip-flops with illegal-SR tracking.
module multi_mode_ff_bank
   import ff_bank_pkg::*;
#(
   parameter int               WIDTH          = 8,
   parameter logic [WIDTH-1:0] RESET_VAL      = '0,
   parameter int               SR_BOTH_POLICY = POL_HOLD,
   parameter int               CNT_W          = 8
) (
   input logic                clk,
   input logic                rst_n,
   multi_mode_ff_bank_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] flags_r;
   logic [WIDTH-1:0] hit;
   logic [CNT_W-1:0] cnt_r;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_cell #(
         .RESET_BIT      (RESET_VAL[i]),
         .SR_BOTH_POLICY (SR_BOTH_POLICY)
      ) u_cell (
         .clk          (clk),
         .rst_n        (rst_n),
         .en           (bus.en),
         .mode         (bus.mode),
         .a            (bus.a[i]),
         .b            (bus.b[i]),
         .illegal_clr  (bus.illegal_clr),
         .q            (q_r[i]),
         .illegal_flag (flags_r[i]),
         .illegal_hit  (hit[i])
      );
   end

   // One count per cycle with any illegal bit; clear restarts the count at this cycle's event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_r <= '0;
      else if (|hit)
         cnt_r <= bus.illegal_clr ? CNT_W'(1)
                : (cnt_r == CNT_MAX) ? cnt_r
                : cnt_r + CNT_W'(1);
      else if (bus.illegal_clr)
         cnt_r <= '0;
   end

   assign bus.q             = q_r;
   assign bus.q_bar         = ~q_r;
   assign bus.illegal_flags = flags_r;
   assign bus.illegal_cnt   = cnt_r;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed self-checking bench: three bank configurations exercised in sequence.
module tb_multi_mode_ff_bank;
   import ff_bank_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(8)) b0 ();
   multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(8)) b3 ();
   multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(2)) b2 ();

   multi_mode_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_BOTH_POLICY(POL_HOLD), .CNT_W(8))
      u_pol0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   multi_mode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_BOTH_POLICY(POL_TGL), .CNT_W(8))
      u_pol3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   multi_mode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_BOTH_POLICY(POL_HOLD), .CNT_W(2))
      u_cnt2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b1;
      b0.en = 1'b0; b0.mode = MODE_SR; b0.a = '0; b0.b = '0; b0.illegal_clr = 1'b0;
      b3.en = 1'b0; b3.mode = MODE_SR; b3.a = '0; b3.b = '0; b3.illegal_clr = 1'b0;
      b2.en = 1'b0; b2.mode = MODE_SR; b2.a = '0; b2.b = '0; b2.illegal_clr = 1'b0;

      // asynchronous reset mid-cycle, observed before any clock edge
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_q",     64'(b0.q), 64'hA5);
      check("rst_qbar",  64'(b0.q_bar), 64'h5A);
      check("rst_flags", 64'(b0.illegal_flags), 64'h00);
      check("rst_cnt",   64'(b0.illegal_cnt), 64'h00);
      check("rst_q_p3",  64'(b3.q), 64'h00);
      check("rst_q_c2",  64'(b2.q), 64'h00);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // SR sweep on bit 0, policy hold; first clear all bits with R
      b0.en = 1'b1; b0.mode = MODE_SR; b0.a = 8'h00; b0.b = 8'hFF;
      tick();
      check("sr_clear", 64'(b0.q), 64'h00);
      b0.a = 8'h00; b0.b = 8'h00; tick(); check("sr_00", 64'(b0.q), 64'h00);
      b0.a = 8'h00; b0.b = 8'h01; tick(); check("sr_01", 64'(b0.q), 64'h00);
      b0.a = 8'h01; b0.b = 8'h00; tick(); check("sr_10", 64'(b0.q), 64'h01);
      b0.a = 8'h01; b0.b = 8'h01; tick(); check("sr_11_hold", 64'(b0.q), 64'h01);
      check("sr_flags", 64'(b0.illegal_flags), 64'h01);
      check("sr_cnt",   64'(b0.illegal_cnt), 64'h01);
      b0.en = 1'b0; b0.a = '0; b0.b = '0;

      // policy toggle, SR 11 on all bits for three edges
      b3.en = 1'b1; b3.mode = MODE_SR; b3.a = 8'hFF; b3.b = 8'hFF;
      tick(); check("tgl_1", 64'(b3.q), 64'hFF);
      tick(); check("tgl_2", 64'(b3.q), 64'h00);
      tick(); check("tgl_3", 64'(b3.q), 64'hFF);
      check("tgl_cnt",   64'(b3.illegal_cnt), 64'h03);
      check("tgl_flags", 64'(b3.illegal_flags), 64'hFF);

      // clear with en low, then JK 11, D, T
      b3.en = 1'b0; b3.illegal_clr = 1'b1;
      tick();
      b3.illegal_clr = 1'b0;
      check("clr_flags", 64'(b3.illegal_flags), 64'h00);
      check("clr_cnt",   64'(b3.illegal_cnt), 64'h00);
      check("clr_q",     64'(b3.q), 64'hFF);
      b3.en = 1'b1; b3.mode = MODE_JK; b3.a = 8'hFF; b3.b = 8'hFF;
      tick(); check("jk_1", 64'(b3.q), 64'h00);
      tick(); check("jk_2", 64'(b3.q), 64'hFF);
      b3.mode = MODE_D; b3.a = 8'h3C; b3.b = 8'hFF;
      tick(); check("d_3c", 64'(b3.q), 64'h3C);
      b3.mode = MODE_T; b3.a = 8'h0F; b3.b = 8'hA5;
      tick(); check("t_0f", 64'(b3.q), 64'h33);
      check("t_qbar",   64'(b3.q_bar), 64'hCC);
      check("jk_flags", 64'(b3.illegal_flags), 64'h00);
      check("jk_cnt",   64'(b3.illegal_cnt), 64'h00);
      b3.en = 1'b0;

      // saturation of a 2-bit counter
      b2.en = 1'b1; b2.mode = MODE_SR; b2.a = 8'h01; b2.b = 8'h01;
      tick(); check("sat_1", 64'(b2.illegal_cnt), 64'h1);
      tick(); check("sat_2", 64'(b2.illegal_cnt), 64'h2);
      tick(); check("sat_3", 64'(b2.illegal_cnt), 64'h3);
      tick(); check("sat_4", 64'(b2.illegal_cnt), 64'h3);
      tick(); check("sat_5", 64'(b2.illegal_cnt), 64'h3);
      check("sat_flags", 64'(b2.illegal_flags), 64'h01);
      check("sat_q",     64'(b2.q), 64'h00);

      // clear coincident with an illegal event on bit 2
      b2.a = 8'h04; b2.b = 8'h04; b2.illegal_clr = 1'b1;
      tick();
      b2.illegal_clr = 1'b0;
      check("clrset_flags", 64'(b2.illegal_flags), 64'h04);
      check("clrset_cnt",   64'(b2.illegal_cnt), 64'h1);

      // load a pattern, then en low must freeze everything
      b2.mode = MODE_D; b2.a = 8'h5A; b2.b = 8'hFF;
      tick();
      check("d_load", 64'(b2.q), 64'h5A);
      check("d_noflag", 64'(b2.illegal_cnt), 64'h1);
      b2.en = 1'b0; b2.mode = MODE_SR; b2.a = 8'hFF; b2.b = 8'hFF;
      tick();
      check("en0_sr_q",     64'(b2.q), 64'h5A);
      check("en0_sr_flags", 64'(b2.illegal_flags), 64'h04);
      check("en0_sr_cnt",   64'(b2.illegal_cnt), 64'h1);
      b2.mode = MODE_D; b2.a = 8'h00;
      tick();
      check("en0_d_q", 64'(b2.q), 64'h5A);
      b2.illegal_clr = 1'b1;
      tick();
      b2.illegal_clr = 1'b0;
      check("en0_clr_flags", 64'(b2.illegal_flags), 64'h00);
      check("en0_clr_cnt",   64'(b2.illegal_cnt), 64'h0);
      check("en0_clr_q",     64'(b2.q), 64'h5A);

      // reset asserted mid-operation takes effect without a clock edge
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_q_c2",  64'(b2.q), 64'h00);
      check("mid_rst_q_p3",  64'(b3.q), 64'h00);
      check("mid_rst_q_p0",  64'(b0.q), 64'hA5);
      check("mid_rst_cnt",   64'(b0.illegal_cnt), 64'h00);
      check("mid_rst_flags", 64'(b0.illegal_flags), 64'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_mode_ff_bank.md
# multi_mode_ff_bank

Parametrised successor to the team's single-bit SR flip-flop: a bank of WIDTH edge-triggered storage bits that operates at runtime as SR, JK, D or T flip-flops. The bank has a configurable policy for the SR forbidden input (S=R=1), per-bit sticky flags for illegal SR events, and a saturating illegal-event counter. It is the generic state-bit primitive for control and status logic, replacing hand-instantiated single SR flops.

## Interface
- WIDTH, 8: number of storage bits (1..64).
- RESET_VAL, all zeros: WIDTH-bit value loaded into q on reset.
- SR_BOTH_POLICY, 0: SR-mode response to S=R=1. 0 = hold, 1 = set, 2 = reset, 3 = toggle.
- CNT_W, 8: width of the illegal-event counter.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  update enable; when low, all state holds.
- mode  in  2  00 SR, 01 JK, 10 D, 11 T; sampled on the same edge as the data.
- a  in  WIDTH  S / J / D / T input per bit.
- b  in  WIDTH  R / K input per bit; ignored in D and T modes.
- illegal_clr  in  1  synchronous clear of illegal_flags and illegal_cnt.
- q  out  WIDTH  stored state.
- q_bar  out  WIDTH  always the bitwise complement of q.
- illegal_flags  out  WIDTH  sticky per-bit flag: S=R=1 was seen in SR mode.
- illegal_cnt  out  CNT_W  saturating count of cycles with at least one illegal bit.

## Operation
- Reset (rst_n low, asynchronous): q=RESET_VAL, q_bar=~RESET_VAL, illegal_flags=0, illegal_cnt=0. Outputs hold these values while rst_n is low. Release takes effect at the first rising clk edge after rst_n goes high.
- Next-state rules per bit i on an edge with en=1:
  - SR: 10 gives 1; 01 gives 0; 00 holds; 11 follows SR_BOTH_POLICY.
  - JK: 10 gives 1; 01 gives 0; 00 holds; 11 toggles.
  - D: q=a.
  - T: a=1 toggles, a=0 holds.
- en=0: q holds, no illegal detection, and the counter does not increment. illegal_clr still acts.
- Illegal event: mode=SR, en=1, a[i]&b[i]=1.
  - It sets illegal_flags[i].
  - illegal_cnt increments by exactly 1 per cycle, regardless of how many bits are illegal in that cycle.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
- illegal_clr:
  - Clears flags and counter at the edge.
  - If an illegal event occurs on the same edge, the set wins: the flag for that bit ends at 1 and the counter ends at 1; all other flags are cleared.
- JK 11 is never illegal and never flags.
- Mode changes take effect on the edge where the new mode is sampled; there is no pipeline and no drain.

## Timing
- Latency: inputs sampled at edge N appear on q after edge N with zero added cycles. q_bar is a combinational complement of the q register, with no extra flop.
- illegal_flags and illegal_cnt update on the same edge as q.
- Reset asserted mid-operation clears everything immediately, without waiting for clk. No partial update may be observable.
- No combinational path from any input to any output.

## Structure
- Package ff_bank_pkg:
  - mode_e enum (MODE_SR, MODE_JK, MODE_D, MODE_T).
  - Policy constants POL_HOLD, POL_SET, POL_RST, POL_TGL.
  - Function next_bit(mode, policy, a, b, q) returning the next state for one bit.
- Sub-module ff_cell holds one bit's register plus illegal detection. The top generates WIDTH instances and owns the shared counter and the clear logic.

## Test plan
- Reset: drive rst_n=0 mid-cycle with RESET_VAL=8'hA5 -> q=A5, q_bar=5A, flags=0, cnt=0 immediately, before any clk edge.
- SR sweep on bit 0 with policy 0, inputs 00,01,10,11 in sequence from q=0 -> q=0,0,1,1. Flag bit 0 set after the 11 cycle; cnt=1.
- Policy 3, SR 11 held for 3 edges on all bits from q=00 -> q=FF, 00, FF; cnt=3; flags=FF.
- JK 11 for 2 edges, then D a=3C, then T a=0F -> q=~q, q, 3C, 33. Flags and cnt remain 0.
- Saturation with CNT_W=2: 5 illegal cycles -> cnt=3. Then illegal_clr together with an illegal event on bit 2 -> flags=04, cnt=1.
- en=0 with SR 11 and D inputs -> q, flags and cnt all unchanged. illegal_clr with en=0 -> flags=0, cnt=0.
